// File: rtl/wide_issue_buffer.sv
// Multi-lane circular issue buffer: up to LANES entries pushed and popped per cycle,
// with a combinational fall-through head window and a sticky overflow flag.
module wide_issue_buffer #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned CW = $clog2(LANES + 1),
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned SW = AW + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [CW-1:0]                  in_num,
  input  logic [LANES-1:0][DATA_W-1:0]   in_data,
  output logic                           in_ready,
  input  logic [CW-1:0]                  pop_num,
  output logic [LANES-1:0][DATA_W-1:0]   out_data,
  output logic [LANES-1:0]               out_valid,
  output logic [SW-1:0]                  size,
  output logic [SW-1:0]                  size_left,
  output logic                           overflow_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     hd_q, hd_d, tl_q, tl_d;
  logic [SW-1:0]     size_q, size_d;
  logic [SW-1:0]     in_num_w, pop_num_w, eff_pop, push_cnt;
  logic              ovf_q, ovf_d;
  logic              push_ok, reject;

  // Occupancy is tracked explicitly so full and empty never alias on equal pointers.
  always_comb begin
    in_num_w  = SW'(in_num);
    pop_num_w = SW'(pop_num);
    size_left = SW'(DEPTH) - size_q;
    in_ready  = in_num_w <= size_left;
    reject    = in_num_w > size_left;
    push_ok   = (in_num != '0) && in_ready && !flush;
    push_cnt  = push_ok ? in_num_w : '0;
    eff_pop   = (pop_num_w > size_q) ? size_q : pop_num_w;
    hd_d      = hd_q + eff_pop[AW-1:0];
    tl_d      = tl_q + push_cnt[AW-1:0];
    size_d    = size_q + push_cnt - eff_pop;
    ovf_d     = ovf_q | reject;
    if (flush) begin
      hd_d   = '0;
      tl_d   = '0;
      size_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_q   <= '0;
      tl_q   <= '0;
      size_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      hd_q   <= hd_d;
      tl_q   <= tl_d;
      size_q <= size_d;
      ovf_q  <= ovf_d;
    end
  end

  // Entry storage carries no reset; only valid lanes are ever exposed.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) < in_num) begin
          mem_q[tl_q + AW'(i)] <= in_data[i];
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < LANES; i++) begin
      out_valid[i] = size_q > SW'(i);
      if (out_valid[i]) begin
        out_data[i] = mem_q[hd_q + AW'(i)];
      end
    end
  end

  assign size         = size_q;
  assign overflow_err = ovf_q;

endmodule
